// File: rtl/column_scheduler_if.sv
// Port bundle between column_scheduler (master) and its neighbours: framebuffer_sync,
// the LED driver loader and column_mux (slave side of the modport pair).
interface column_scheduler_if #(
  parameter int N_COLUMNS = 8
);
  // Pulse semantics: slice_start, clr_err, data_req, column_ready and slice_done are
  // single-cycle strobes with no back-pressure; data_ready is a level acknowledging data_req.
  logic                         slice_start;
  logic                         data_ready;
  logic                         clr_err;
  logic                         data_req;
  logic [$clog2(N_COLUMNS)-1:0] column_idx;
  logic                         column_ready;
  logic                         slice_done;
  logic                         busy;
  logic                         underrun;
  logic                         overrun;
  logic [2:0]                   fsm_state;

  modport master (
    input  slice_start, data_ready, clr_err,
    output data_req, column_idx, column_ready, slice_done, busy, underrun, overrun, fsm_state
  );

  modport slave (
    output slice_start, data_ready, clr_err,
    input  data_req, column_idx, column_ready, slice_done, busy, underrun, overrun, fsm_state
  );
endinterface

// File: rtl/column_scheduler.sv
// Column sequencer for one LED multiplex slice: request, wait for load, fire, hold drive window.
// Optional anti-ghosting dead time after each column is enabled by COLUMN_SCHED_BLANK_EN.
module column_scheduler #(
  parameter int N_COLUMNS      = 8,
  parameter int DRIVE_CYCLES   = 330,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int BLANK_CYCLES   = 4
) (
  input  logic                clk_33,
  input  logic                nrst,
  column_scheduler_if.master  bus
);
  localparam int IW = $clog2(N_COLUMNS);
  localparam int DW = $clog2(DRIVE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_COL    = IW'(N_COLUMNS - 1);
  localparam logic [DW-1:0] DRIVE_LAST  = DW'(DRIVE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DATA = 3'd2,
    FIRE      = 3'd3,
    DRIVE     = 3'd4,
    BLANK     = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t         state;
  logic [IW-1:0]  col;
  logic [DW-1:0]  drive_cnt;
  logic [TW-1:0]  wait_cnt;
`ifdef COLUMN_SCHED_BLANK_EN
  localparam int BW = $clog2(BLANK_CYCLES);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  logic [BW-1:0]  blank_cnt;
`endif

  logic last_col;
  logic timeout_hit;
  logic overrun_hit;

  assign last_col    = (col == LAST_COL);
  assign timeout_hit = (state == WAIT_DATA) && !bus.data_ready && (wait_cnt == TIMEOUT_LAST);
  assign overrun_hit = bus.slice_start && (state != IDLE);

  assign bus.column_idx = col;
  assign bus.fsm_state  = state;

  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      state            <= IDLE;
      col              <= '0;
      drive_cnt        <= '0;
      wait_cnt         <= '0;
`ifdef COLUMN_SCHED_BLANK_EN
      blank_cnt        <= '0;
`endif
      bus.data_req     <= 1'b0;
      bus.column_ready <= 1'b0;
      bus.slice_done   <= 1'b0;
      bus.busy         <= 1'b0;
      bus.underrun     <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      bus.data_req     <= 1'b0;
      bus.column_ready <= 1'b0;
      bus.slice_done   <= 1'b0;

      // A fault in the same cycle as clr_err keeps its flag set.
      if (timeout_hit)      bus.underrun <= 1'b1;
      else if (bus.clr_err) bus.underrun <= 1'b0;
      if (overrun_hit)      bus.overrun  <= 1'b1;
      else if (bus.clr_err) bus.overrun  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.slice_start) begin
            state        <= REQ;
            col          <= '0;
            bus.data_req <= 1'b1;
            bus.busy     <= 1'b1;
          end
        end
        REQ: begin
          state    <= WAIT_DATA;
          wait_cnt <= '0;
        end
        WAIT_DATA: begin
          if (bus.data_ready) begin
            state            <= FIRE;
            bus.column_ready <= 1'b1;
          end else if (timeout_hit) begin
`ifdef COLUMN_SCHED_BLANK_EN
            state     <= BLANK;
            blank_cnt <= '0;
`else
            state          <= last_col ? DONE : REQ;
            bus.slice_done <= last_col;
            bus.data_req   <= !last_col;
            if (!last_col) col <= col + 1'b1;
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FIRE: begin
          state     <= DRIVE;
          drive_cnt <= '0;
        end
        DRIVE: begin
          if (drive_cnt == DRIVE_LAST) begin
`ifdef COLUMN_SCHED_BLANK_EN
            state     <= BLANK;
            blank_cnt <= '0;
`else
            state          <= last_col ? DONE : REQ;
            bus.slice_done <= last_col;
            bus.data_req   <= !last_col;
            if (!last_col) col <= col + 1'b1;
`endif
          end else begin
            drive_cnt <= drive_cnt + 1'b1;
          end
        end
`ifdef COLUMN_SCHED_BLANK_EN
        BLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            state          <= last_col ? DONE : REQ;
            bus.slice_done <= last_col;
            bus.data_req   <= !last_col;
            if (!last_col) col <= col + 1'b1;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
`endif
        DONE: begin
          state    <= IDLE;
          col      <= '0;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_column_scheduler.sv
// Directed bench for column_scheduler: full slice, column timeout with clr_err race,
// overrun (mid-slice and on DONE), asynchronous reset mid-drive and restart.
module tb_column_scheduler;
  localparam int DRIVE = 330;
  localparam int TO    = 64;
`ifdef COLUMN_SCHED_BLANK_EN
  localparam int BL = 4;
`else
  localparam int BL = 0;
`endif
  localparam int P    = DRIVE + 3 + BL;
  localparam int DONE_FULL = 8 * P + 1;
  localparam int TOE  = 1 + 3 * P + TO;
  localparam int DONE_SKIP = TOE + BL + 4 * P + 1;
  localparam int OV   = 3 + 5 * P + 100;
  localparam int RST_AT = 3 + 2 * P + 50;

  // clock / reset
  logic clk_33 = 1'b0;
  logic nrst   = 1'b0;
  int   cyc    = 0;
  always #5 clk_33 = ~clk_33;
  always @(posedge clk_33) cyc <= cyc + 1;

  column_scheduler_if #(.N_COLUMNS(8)) bus ();

  column_scheduler dut (
    .clk_33 (clk_33),
    .nrst   (nrst),
    .bus    (bus)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  int req_q[$];
  int rdy_q[$];
  int done_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // exp_q holds time*8+idx for each expected pulse, compared in order
  task automatic check_rdy(input string tag);
    int got;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      got = (rdy_q.size() > 0) ? rdy_q.pop_front() : -1;
      check($sformatf("%s_ready%0d", tag, n), got, exp_q.pop_front());
      n++;
    end
    check({tag, "_ready_extra"}, rdy_q.size(), 0);
  endtask

  task automatic check_req(input string tag);
    int got;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      got = (req_q.size() > 0) ? req_q.pop_front() : -1;
      check($sformatf("%s_req%0d", tag, n), got, exp_q.pop_front());
      n++;
    end
    check({tag, "_req_extra"}, req_q.size(), 0);
  endtask

  task automatic check_done(input string tag, input int exp_t);
    check({tag, "_done_cnt"}, done_q.size(), 1);
    check({tag, "_done_time"}, (done_q.size() > 0) ? done_q[0] : -1, exp_t);
  endtask

  // driver: rel is the clock edge (counted from the slice_start edge) at which
  // inputs driven now are sampled and outputs seen now are valid
  task automatic run_slice(input int mode, input int end_rel);
    int t0;
    int rel;
    req_q.delete();
    rdy_q.delete();
    done_q.delete();
    @(negedge clk_33);
    bus.slice_start = 1'b1;
    t0 = cyc + 1;
    for (int n = 0; n < end_rel; n++) begin
      @(negedge clk_33);
      bus.slice_start = 1'b0;
      bus.clr_err     = 1'b0;
      rel = cyc + 1 - t0;
      if (bus.data_req)     req_q.push_back(rel * 8 + int'(bus.column_idx));
      if (bus.column_ready) rdy_q.push_back(rel * 8 + int'(bus.column_idx));
      if (bus.slice_done)   done_q.push_back(rel);
      case (mode)
        1: begin
          bus.data_ready = (bus.column_idx != 3'd3);
          if (rel == TOE) begin
            check("underrun_before_timeout", bus.underrun, 1'b0);
            bus.clr_err = 1'b1;
          end
          if (rel == TOE + 1) begin
            check("underrun_fault_beats_clr", bus.underrun, 1'b1);
            bus.clr_err = 1'b1;
          end
          if (rel == TOE + 2) check("underrun_clr_alone", bus.underrun, 1'b0);
        end
        2: begin
          if (rel == OV) bus.slice_start = 1'b1;
          if (rel == OV + 1) begin
            check("overrun_mid_slice", bus.overrun, 1'b1);
            check("overrun_col_kept", bus.column_idx, 3'd5);
          end
          if (rel == OV + 10) bus.clr_err = 1'b1;
          if (rel == OV + 11) check("overrun_cleared", bus.overrun, 1'b0);
          if (rel == DONE_FULL) bus.slice_start = 1'b1;
          if (rel == DONE_FULL + 1) begin
            check("overrun_on_done", bus.overrun, 1'b1);
            check("busy_after_done", bus.busy, 1'b0);
          end
        end
        3: begin
          if (rel == RST_AT) begin
            check("pre_reset_col", bus.column_idx, 3'd2);
            check("pre_reset_busy", bus.busy, 1'b1);
            nrst = 1'b0;
            #1;
            check("async_reset_outputs",
                  {bus.data_req, bus.column_ready, bus.slice_done, bus.busy,
                   bus.underrun, bus.overrun, bus.column_idx, bus.fsm_state}, 0);
            break;
          end
        end
        default: bus.data_ready = 1'b1;
      endcase
    end
  endtask

  initial begin
    bus.slice_start = 1'b0;
    bus.data_ready  = 1'b1;
    bus.clr_err     = 1'b0;
    repeat (3) @(negedge clk_33);
    check("reset_outputs",
          {bus.data_req, bus.column_ready, bus.slice_done, bus.busy,
           bus.underrun, bus.overrun, bus.column_idx, bus.fsm_state}, 0);
    nrst = 1'b1;
    @(negedge clk_33);

    // full slice, data always ready
    run_slice(0, DONE_FULL + 3);
    for (int k = 0; k < 8; k++) exp_q.push_back((1 + P * k) * 8 + k);
    check_req("s1");
    for (int k = 0; k < 8; k++) exp_q.push_back((3 + P * k) * 8 + k);
    check_rdy("s1");
    check_done("s1", DONE_FULL);
    check("s1_underrun", bus.underrun, 1'b0);
    check("s1_overrun", bus.overrun, 1'b0);
    check("s1_busy_end", bus.busy, 1'b0);

    // column 3 starved: skipped after timeout, rest of slice continues
    run_slice(1, DONE_SKIP + 3);
    bus.data_ready = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back((1 + P * k) * 8 + k);
    for (int k = 4; k < 8; k++) exp_q.push_back((TOE + BL + 1 + P * (k - 4)) * 8 + k);
    check_req("s2");
    for (int k = 0; k < 3; k++) exp_q.push_back((3 + P * k) * 8 + k);
    for (int k = 4; k < 8; k++) exp_q.push_back((TOE + BL + 3 + P * (k - 4)) * 8 + k);
    check_rdy("s2");
    check_done("s2", DONE_SKIP);

    // slice_start while busy and while in DONE
    run_slice(2, DONE_FULL + 20);
    for (int k = 0; k < 8; k++) exp_q.push_back((3 + P * k) * 8 + k);
    check_rdy("s3");
    check_done("s3", DONE_FULL);
    check("s3_req_cnt", req_q.size(), 8);
    check("s3_idle_after", bus.busy, 1'b0);

    // asynchronous reset during drive of column 2, then restart
    run_slice(3, RST_AT + 5);
    check("s4_no_done", done_q.size(), 0);
    @(negedge clk_33);
    check("s4_held_reset_state", bus.fsm_state, 3'd0);
    nrst = 1'b1;
    @(negedge clk_33);
    run_slice(0, DONE_FULL + 3);
    for (int k = 0; k < 8; k++) exp_q.push_back((3 + P * k) * 8 + k);
    check_rdy("s4");
    check_done("s4", DONE_FULL);
    check("s4_req_first", (req_q.size() > 0) ? req_q[0] : -1, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
